// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave: default frame width,
// FSM state encodings and the serial clock idle level.
package spi_pkg;

   localparam int DWIDTH_DEF = 16;

   localparam logic SCK_IDLE = 1'b1;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACTIVE = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one asynchronous input,
// with a configurable value forced during reset.
module spi_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic nRst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/spi_slave.sv
// SPI slave (SCK idles high, MISO on fall, MOSI sampled on rise).
// Define SPI_SLAVE_OVERRUN_EN to enable the sticky rx_overrun flag.
module spi_slave
   import spi_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_DEF
) (
   input  logic              clk,
   input  logic              nRst,
   input  logic              SCK,
   input  logic              SS,
   input  logic              MOSI,
   output logic              MISO,
   input  logic [DWIDTH-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DWIDTH-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              rx_overrun,
   input  logic              ovr_clr,
   output logic              busy
);

   localparam int CW = $clog2(DWIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(DWIDTH - 1);

   logic              sck_s, ss_s, mosi_s;
   logic              sck_d, ss_d;
   logic              sck_rise, sck_fall;
   logic              ss_fall, ss_rise;
   logic [1:0]        warm;
   logic              armed;
   logic [1:0]        state;
   logic [CW-1:0]     bit_cnt;
   logic [CW-1:0]     msb_idx;
   logic [DWIDTH-1:0] tx_buf;
   logic              buf_full;
   logic [DWIDTH-1:0] tx_shift;
   logic [DWIDTH-1:0] load_word;
   logic [DWIDTH-2:0] rx_shift;
   logic [DWIDTH-1:0] rx_word;
   logic              enter;
   logic              last_rise;
   logic              tx_accept;

   spi_sync #(.RST_VAL(SCK_IDLE)) u_sync_sck (
      .clk  (clk),
      .nRst (nRst),
      .d    (SCK),
      .q    (sck_s)
   );

   spi_sync #(.RST_VAL(1'b1)) u_sync_ss (
      .clk  (clk),
      .nRst (nRst),
      .d    (SS),
      .q    (ss_s)
   );

   spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
      .clk  (clk),
      .nRst (nRst),
      .d    (MOSI),
      .q    (mosi_s)
   );

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         sck_d <= SCK_IDLE;
         ss_d  <= 1'b1;
      end else begin
         sck_d <= sck_s;
         ss_d  <= ss_s;
      end
   end

   // The SS synchronizer reads 1 right after reset even if the
   // master still holds SS low; only a high seen once the chain
   // carries real samples arms the next frame start.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         warm  <= 2'b00;
         armed <= 1'b0;
      end else begin
         warm  <= {warm[0], 1'b1};
         armed <= armed | (warm[1] & ss_s);
      end
   end

   assign sck_rise  = sck_s & ~sck_d;
   assign sck_fall  = ~sck_s & sck_d;
   assign ss_fall   = armed & ss_d & ~ss_s;
   assign ss_rise   = ss_s & ~ss_d;

   assign enter     = (state == IDLE) & ss_fall;
   assign load_word = buf_full ? tx_buf : '0;
   assign msb_idx   = LAST - bit_cnt;
   assign rx_word   = {rx_shift, mosi_s};
   assign last_rise = (state == ACTIVE) & ~ss_rise & sck_rise &
                      (bit_cnt == LAST);

   assign tx_accept = tx_valid & ~buf_full;
   assign tx_ready  = ~buf_full;
   assign busy      = (state == ACTIVE);

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         tx_shift <= '0;
         rx_shift <= '0;
         MISO     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               MISO <= 1'b0;
               if (enter) begin
                  state    <= ACTIVE;
                  bit_cnt  <= '0;
                  tx_shift <= load_word;
                  MISO     <= load_word[DWIDTH-1];
               end
            end
            ACTIVE: begin
               if (ss_rise) begin
                  state <= IDLE;
                  MISO  <= 1'b0;
               end else if (sck_rise) begin
                  rx_shift <= rx_word[DWIDTH-2:0];
                  bit_cnt  <= bit_cnt + 1'b1;
                  if (bit_cnt == LAST) begin
                     state <= DONE;
                     MISO  <= 1'b0;
                  end
               end else if (sck_fall) begin
                  MISO <= tx_shift[msb_idx];
               end
            end
            DONE: begin
               MISO <= 1'b0;
               if (ss_rise) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               MISO  <= 1'b0;
            end
         endcase
      end
   end

   // An accept that lands on the frame-start cycle fills the buffer
   // for the following frame; the current frame already took zeros.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         tx_buf   <= '0;
         buf_full <= 1'b0;
      end else if (tx_accept) begin
         tx_buf   <= tx_data;
         buf_full <= 1'b1;
      end else if (enter) begin
         buf_full <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         rx_data  <= '0;
         rx_valid <= 1'b0;
      end else if (last_rise) begin
         rx_data  <= rx_word;
         rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
         rx_valid <= 1'b0;
      end
   end

`ifdef SPI_SLAVE_OVERRUN_EN
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         rx_overrun <= 1'b0;
      end else if (last_rise && rx_valid) begin
         rx_overrun <= 1'b1;
      end else if (ovr_clr) begin
         rx_overrun <= 1'b0;
      end
   end
`else
   logic unused_ovr_clr;
   assign unused_ovr_clr = ovr_clr;
   assign rx_overrun     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a task-driven SPI master with a scoreboard
// of expected rx words and expected MISO words per frame.
module tb_spi_slave;

   localparam int DW = 16;
   localparam int HP = 4;

`ifdef SPI_SLAVE_OVERRUN_EN
   localparam logic OVR_ON = 1'b1;
`else
   localparam logic OVR_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          nRst;
   logic          SCK, SS, MOSI, MISO;
   logic [DW-1:0] tx_data;
   logic          tx_valid, tx_ready;
   logic [DW-1:0] rx_data;
   logic          rx_valid, rx_ready;
   logic          rx_overrun, ovr_clr, busy;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] exp_rx[$];
   logic [DW-1:0] exp_tx[$];

   always #5 clk = ~clk;

   spi_slave #(.DWIDTH(DW)) dut (
      .clk        (clk),
      .nRst       (nRst),
      .SCK        (SCK),
      .SS         (SS),
      .MOSI       (MOSI),
      .MISO       (MISO),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .rx_overrun (rx_overrun),
      .ovr_clr    (ovr_clr),
      .busy       (busy)
   );

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one frame; optionally offers a tx word exactly on the
   // cycle the slave's synchronized SS fall is acted upon.
   task automatic spi_frame(input logic [DW-1:0] mw, input int nrise,
                            input logic keep_ss, input logic inject,
                            input logic [DW-1:0] iw,
                            output logic [DW-1:0] sw);
      sw = '0;
      SS = 1'b0;
      tick(2);
      if (inject) begin
         tx_data  = iw;
         tx_valid = 1'b1;
      end
      tick(1);
      tx_valid = 1'b0;
      tick(HP);
      for (int i = 0; i < nrise; i++) begin
         SCK  = 1'b0;
         MOSI = mw[DW-1-i];
         tick(HP);
         SCK = 1'b1;
         sw[DW-1-i] = MISO;
         tick(HP);
      end
      if (!keep_ss) begin
         SS = 1'b1;
         tick(6);
      end
   endtask

   task automatic consume();
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      tick(1);
   endtask

   task automatic test_reset();
      nRst = 1'b0;
      tick(3);
      n_tests++;
      if (MISO !== 1'b0) begin
         n_fail++; $display("FAIL reset_miso: got %b want 0", MISO);
      end
      n_tests++;
      if (tx_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready);
      end
      n_tests++;
      if (rx_data !== '0 || rx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_rx: got %h/%b want 0000/0", rx_data, rx_valid);
      end
      n_tests++;
      if (rx_overrun !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got ovr %b busy %b want 0 0",
                  rx_overrun, busy);
      end
      nRst = 1'b1;
      tick(4);
   endtask

   task automatic test_basic();
      logic [DW-1:0] sw, e;
      tx_data  = 16'hA5C3;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
      n_tests++;
      if (tx_ready !== 1'b0) begin
         n_fail++; $display("FAIL load_tx_ready: got %b want 0", tx_ready);
      end
      exp_rx.push_back(16'h1234);
      exp_tx.push_back(16'hA5C3);
      spi_frame(16'h1234, DW, 1'b0, 1'b0, '0, sw);
      e = exp_tx.pop_front();
      n_tests++;
      if (sw !== e) begin
         n_fail++; $display("FAIL basic_miso: got %h want %h", sw, e);
      end
      e = exp_rx.pop_front();
      n_tests++;
      if (rx_data !== e || rx_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_rx: got %h/%b want %h/1", rx_data, rx_valid, e);
      end
      n_tests++;
      if (busy !== 1'b0 || tx_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_after: got busy %b txr %b want 0 1",
                  busy, tx_ready);
      end
      consume();
      n_tests++;
      if (rx_valid !== 1'b0) begin
         n_fail++; $display("FAIL basic_consume: got %b want 0", rx_valid);
      end
   endtask

   task automatic test_no_tx();
      logic [DW-1:0] sw, e;
      exp_rx.push_back(16'hFFFF);
      exp_tx.push_back(16'h0000);
      spi_frame(16'hFFFF, DW, 1'b0, 1'b0, '0, sw);
      e = exp_tx.pop_front();
      n_tests++;
      if (sw !== e) begin
         n_fail++; $display("FAIL notx_miso: got %h want %h", sw, e);
      end
      e = exp_rx.pop_front();
      n_tests++;
      if (rx_data !== e || rx_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL notx_rx: got %h/%b want %h/1", rx_data, rx_valid, e);
      end
      consume();
   endtask

   task automatic test_abort();
      logic [DW-1:0] sw, e;
      spi_frame(16'hAAAA, 7, 1'b0, 1'b0, '0, sw);
      n_tests++;
      if (rx_valid !== 1'b0 || rx_data !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL abort_rx: got %h/%b want ffff/0", rx_data, rx_valid);
      end
      n_tests++;
      if (busy !== 1'b0 || MISO !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_idle: got busy %b miso %b want 0 0", busy, MISO);
      end
      exp_rx.push_back(16'h0F0F);
      spi_frame(16'h0F0F, DW, 1'b0, 1'b0, '0, sw);
      e = exp_rx.pop_front();
      n_tests++;
      if (rx_data !== e || rx_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_next: got %h/%b want %h/1", rx_data, rx_valid, e);
      end
      consume();
   endtask

   task automatic test_overrun();
      logic [DW-1:0] sw, e;
      exp_rx.push_back(16'h1111);
      exp_rx.push_back(16'h2222);
      spi_frame(16'h1111, DW, 1'b0, 1'b0, '0, sw);
      e = exp_rx.pop_front();
      n_tests++;
      if (rx_data !== e || rx_overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL ovr_first: got %h ovr %b want %h ovr 0",
                  rx_data, rx_overrun, e);
      end
      spi_frame(16'h2222, DW, 1'b0, 1'b0, '0, sw);
      e = exp_rx.pop_front();
      n_tests++;
      if (rx_data !== e || rx_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL ovr_second: got %h/%b want %h/1", rx_data, rx_valid, e);
      end
      n_tests++;
      if (rx_overrun !== OVR_ON) begin
         n_fail++;
         $display("FAIL ovr_flag: got %b want %b", rx_overrun, OVR_ON);
      end
      ovr_clr = 1'b1;
      tick(1);
      ovr_clr = 1'b0;
      n_tests++;
      if (rx_overrun !== 1'b0) begin
         n_fail++; $display("FAIL ovr_clear: got %b want 0", rx_overrun);
      end
      consume();
   endtask

   task automatic test_tx_coincide();
      logic [DW-1:0] sw, e;
      exp_rx.push_back(16'h00C3);
      exp_tx.push_back(16'h0000);
      spi_frame(16'h00C3, DW, 1'b0, 1'b1, 16'h5555, sw);
      e = exp_tx.pop_front();
      n_tests++;
      if (sw !== e) begin
         n_fail++; $display("FAIL coin_first_miso: got %h want %h", sw, e);
      end
      e = exp_rx.pop_front();
      n_tests++;
      if (rx_data !== e || tx_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL coin_first: got %h txr %b want %h txr 0",
                  rx_data, tx_ready, e);
      end
      consume();
      exp_rx.push_back(16'h3C00);
      exp_tx.push_back(16'h5555);
      spi_frame(16'h3C00, DW, 1'b0, 1'b0, '0, sw);
      e = exp_tx.pop_front();
      n_tests++;
      if (sw !== e) begin
         n_fail++; $display("FAIL coin_second_miso: got %h want %h", sw, e);
      end
      e = exp_rx.pop_front();
      n_tests++;
      if (rx_data !== e || tx_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL coin_second: got %h txr %b want %h txr 1",
                  rx_data, tx_ready, e);
      end
      consume();
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] sw, e;
      spi_frame(16'hBEEF, 8, 1'b1, 1'b0, '0, sw);
      tx_data  = 16'h1357;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
      n_tests++;
      if (busy !== 1'b1 || tx_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_state: got busy %b txr %b want 1 0", busy, tx_ready);
      end
      nRst = 1'b0;
      tick(1);
      n_tests++;
      if (MISO !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_ctl: got miso %b txr %b busy %b want 0 1 0",
                  MISO, tx_ready, busy);
      end
      n_tests++;
      if (rx_data !== '0 || rx_valid !== 1'b0 || rx_overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_rx: got %h/%b ovr %b want 0000/0 ovr 0",
                  rx_data, rx_valid, rx_overrun);
      end
      nRst = 1'b1;
      tick(3);
      for (int i = 0; i < 8; i++) begin
         SCK = 1'b0;
         tick(HP);
         SCK = 1'b1;
         tick(HP);
      end
      n_tests++;
      if (busy !== 1'b0 || rx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_stale_ss: got busy %b rxv %b want 0 0",
                  busy, rx_valid);
      end
      SS = 1'b1;
      tick(6);
      exp_rx.push_back(16'hBEEF);
      exp_tx.push_back(16'h0000);
      spi_frame(16'hBEEF, DW, 1'b0, 1'b0, '0, sw);
      e = exp_tx.pop_front();
      n_tests++;
      if (sw !== e) begin
         n_fail++; $display("FAIL mid_next_miso: got %h want %h", sw, e);
      end
      e = exp_rx.pop_front();
      n_tests++;
      if (rx_data !== e || rx_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_next_rx: got %h/%b want %h/1", rx_data, rx_valid, e);
      end
      consume();
   endtask

   initial begin
      nRst     = 1'b0;
      SCK      = 1'b1;
      SS       = 1'b1;
      MOSI     = 1'b0;
      tx_data  = '0;
      tx_valid = 1'b0;
      rx_ready = 1'b0;
      ovr_clr  = 1'b0;
      test_reset();
      test_basic();
      test_no_tx();
      test_abort();
      test_overrun();
      test_tx_coincide();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
